// File: rtl/alu_mc_if.sv
// Handshake bundle for alu_mc: request side (in_valid/in_ready, A, B, FunSel)
// and result side (out_valid/out_ready, OutALU, Flags = {Z,C,N,O}).
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       FunSel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] OutALU;
  logic [3:0]       Flags;

  modport master (
    output in_valid, A, B, FunSel, out_ready,
    input  in_ready, out_valid, OutALU, Flags
  );

  modport slave (
    input  in_valid, A, B, FunSel, out_ready,
    output in_ready, out_valid, OutALU, Flags
  );
endinterface

// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle arith/logic, one-bit-per-cycle shifts.
// Optional macro ALU_MUL_EN turns FunSel 1001 into a WIDTH-cycle shift-add multiply.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef ALU_MUL_EN
    , MUL = 2'd2
`endif
  } state_t;

  state_t           r_state;
  logic             r_run;
  logic             r_valid;
  logic             r_c;
  logic             r_o;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] r_out;
  logic [3:0]       r_op;
  logic [3:0]       r_flags;
  logic [CW-1:0]    r_cnt;
`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_macc;
  logic [2*WIDTH-1:0] w_pnext;
`endif

  logic             w_ready;
  logic             w_accept;
  logic             w_isShift;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_fres;
  logic [WIDTH:0]   w_sum;
  logic             w_c;
  logic             w_o;
  logic [WIDTH-1:0] w_step;
  logic             w_stepC;
  logic             w_stepO;

  // r_run keeps in_ready low until the first edge after reset release.
  assign w_ready   = r_run && (r_state == IDLE) && (!r_valid || bus.out_ready);
  assign w_accept  = bus.in_valid && w_ready;
  assign w_n       = bus.B[SHW-1:0];
  assign w_isShift = (bus.FunSel >= 4'b1011);

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.OutALU    = r_out;
  assign bus.Flags     = r_flags;

  always_comb begin
    w_res = bus.A;
    w_sum = '0;
    w_c   = r_flags[2];
    w_o   = r_flags[0];
    case (bus.FunSel)
      4'b0000: w_res = bus.A;
      4'b0001: w_res = bus.B;
      4'b0010: w_res = ~bus.A;
      4'b0011: w_res = ~bus.B;
      4'b0100: begin
        w_sum = {1'b0, bus.A} + {1'b0, bus.B};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_o   = (bus.A[MSB] == bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
      end
      4'b0101, 4'b0110: begin
        w_sum = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_o   = (bus.A[MSB] != bus.B[MSB]) && (w_sum[MSB] != bus.A[MSB]);
      end
      4'b0111: w_res = bus.A & bus.B;
      4'b1000: w_res = bus.A | bus.B;
      4'b1001: w_res = ~(bus.A & bus.B);
      4'b1010: w_res = bus.A ^ bus.B;
      default: w_res = bus.A;
    endcase
    // CMP reports A but derives Z/N from the difference.
    w_fres = w_res;
    if (bus.FunSel == 4'b0110) begin
      w_fres = w_sum[MSB:0];
      w_res  = bus.A;
    end
  end

  always_comb begin
    w_step  = r_val;
    w_stepC = r_c;
    w_stepO = r_o;
    case (r_op)
      4'b1011, 4'b1101: begin
        w_step  = {r_val[MSB-1:0], 1'b0};
        w_stepC = r_val[MSB];
      end
      4'b1100: begin
        w_step  = {1'b0, r_val[MSB:1]};
        w_stepC = r_val[0];
      end
      4'b1110: begin
        w_step  = {r_val[MSB], r_val[MSB:1]};
        w_stepC = r_val[0];
      end
      4'b1111: begin
        w_step  = {r_val[0], r_val[MSB:1]};
        w_stepC = r_val[0];
      end
      default: ;
    endcase
    if (r_op == 4'b1101)
      w_stepO = r_o | (r_val[MSB] ^ r_val[MSB-1]);
  end

`ifdef ALU_MUL_EN
  // Multiplier sits in the low half of r_prod and is consumed LSB first.
  assign w_macc  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_val} : '0);
  assign w_pnext = {w_macc, r_prod[MSB:1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_valid <= 1'b0;
      r_c     <= 1'b0;
      r_o     <= 1'b0;
      r_val   <= '0;
      r_out   <= '0;
      r_op    <= '0;
      r_flags <= '0;
      r_cnt   <= '0;
`ifdef ALU_MUL_EN
      r_prod  <= '0;
`endif
    end else begin
      r_run <= 1'b1;
      if (r_valid && bus.out_ready)
        r_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op  <= bus.FunSel;
          r_val <= bus.A;
          r_c   <= r_flags[2];
          r_o   <= (bus.FunSel == 4'b1101) ? 1'b0 : r_flags[0];
          r_cnt <= CW'(w_n);
          if (w_isShift && (w_n != '0))
            r_state <= SHIFT;
`ifdef ALU_MUL_EN
          else if (bus.FunSel == 4'b1001) begin
            r_state <= MUL;
            r_val   <= bus.B;
            r_prod  <= {{WIDTH{1'b0}}, bus.A};
            r_cnt   <= CW'(WIDTH);
          end
`endif
          else begin
            r_out   <= w_res;
            r_flags <= {w_fres == '0, w_c, w_fres[MSB], w_o};
            r_valid <= 1'b1;
          end
        end
        SHIFT: begin
          r_val <= w_step;
          r_c   <= w_stepC;
          r_o   <= w_stepO;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_out   <= w_step;
            r_flags <= {w_step == '0, w_stepC, w_step[MSB], w_stepO};
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          r_prod <= w_pnext;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_out   <= w_pnext[MSB:0];
            r_flags <= {w_pnext[MSB:0] == '0, |w_pnext[2*WIDTH-1:WIDTH],
                        w_pnext[MSB], r_flags[0]};
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed vector table, handshake
// corner sequences, then random operations scored against a behavioural model.
module tb_alu_mc;
  localparam int W  = 8;
  localparam int NV = 20;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   mC;
  bit   mO;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [3:0] flags;
    int         lat;
  } vec_t;

  vec_t vecs [NV];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Issue one op with out_ready=1 and measure latency in cycles after the accept cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               output int gotOut, output int gotFlags, output int lat,
                               output int busyOk);
    int guard;
    @(negedge clk);
    bus.FunSel    = op;
    bus.A         = a;
    bus.B         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 8'($urandom);
    bus.B        = 8'($urandom);
    bus.FunSel   = 4'($urandom);
    lat    = 1;
    busyOk = 1;
    while (!bus.out_valid && lat < 60) begin
      if (bus.in_ready) busyOk = 0;
      @(negedge clk);
      lat++;
    end
    checkOutput("valid", int'(bus.out_valid), 1);
    gotOut   = int'(bus.OutALU);
    gotFlags = int'(bus.Flags);
  endtask

  // Reference: whole-operation arithmetic on ints, flags packed {Z,C,N,O}.
  function automatic void refModel(input int op, input int a, input int b, input bit pc,
                                   input bit po, output int res, output int flags,
                                   output int lat);
    int s, sa, sb, sr, sh, fv;
    bit c, o;
    c = pc; o = po; lat = 1; s = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    res = a;
    case (op)
      0: res = a;
      1: res = b;
      2: res = (~a) & 255;
      3: res = (~b) & 255;
      4: begin
        s = a + b; res = s & 255; c = (s > 255);
        sr = sa + sb; o = (sr > 127) || (sr < -128);
      end
      5, 6: begin
        s = a + (255 - b) + 1; res = s & 255; c = (s > 255);
        sr = sa - sb; o = (sr > 127) || (sr < -128);
      end
      7: res = a & b;
      8: res = a | b;
`ifdef ALU_MUL_EN
      9: begin s = a * b; res = s & 255; c = ((s >> 8) != 0); lat = W + 1; end
`else
      9: res = (~(a & b)) & 255;
`endif
      10: res = a ^ b;
      default: begin
        sh = b % 8;
        if (sh != 0) begin
          lat = sh + 1;
          case (op)
            11, 13: begin
              res = (a << sh) & 255;
              c = (((a >> (8 - sh)) & 1) != 0);
              if (op == 13) begin
                o = 0;
                for (int k = 1; k <= sh; k++)
                  if (((a >> (7 - k)) & 1) != ((a >> 7) & 1)) o = 1;
              end
            end
            12: begin res = a >> sh; c = (((a >> (sh - 1)) & 1) != 0); end
            14: begin sr = sa >>> sh; res = sr & 255; c = (((a >> (sh - 1)) & 1) != 0); end
            default: begin
              res = ((a >> sh) | (a << (8 - sh))) & 255;
              c = (((res >> 7) & 1) != 0);
            end
          endcase
        end
      end
    endcase
    fv = res;
    if (op == 6) begin fv = s & 255; res = a; end
    flags = ((fv == 0) ? 8 : 0) | (c ? 4 : 0) | ((((fv >> 7) & 1) != 0) ? 2 : 0) | (o ? 1 : 0);
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int gOut, gFlags, lat, busy, eOut, eFlags, eLat;
    logic [3:0] rop;
    logic [7:0] ra, rb;

    vecs[0]  = '{4'h4, 8'h33, 8'h0F, 8'h42, 4'b0000, 1};
    vecs[1]  = '{4'h5, 8'h07, 8'hFA, 8'h0D, 4'b0000, 1};
    vecs[2]  = '{4'hD, 8'h80, 8'h01, 8'h00, 4'b1101, 2};
    vecs[3]  = '{4'hC, 8'h33, 8'h03, 8'h06, 4'b0001, 4};
    vecs[4]  = '{4'hF, 8'h80, 8'h00, 8'h80, 4'b0011, 1};
    vecs[5]  = '{4'h6, 8'h05, 8'h05, 8'h05, 4'b1100, 1};
    vecs[6]  = '{4'h7, 8'hAA, 8'hF0, 8'hA0, 4'b0110, 1};
    vecs[7]  = '{4'hA, 8'hFF, 8'hFF, 8'h00, 4'b1100, 1};
`ifdef ALU_MUL_EN
    vecs[8]  = '{4'h9, 8'hF0, 8'h0F, 8'h10, 4'b0100, 9};
`else
    vecs[8]  = '{4'h9, 8'hF0, 8'h0F, 8'hFF, 4'b0110, 1};
`endif
    vecs[9]  = '{4'h4, 8'h7F, 8'h01, 8'h80, 4'b0011, 1};
    vecs[10] = '{4'h2, 8'hFF, 8'h00, 8'h00, 4'b1001, 1};
    vecs[11] = '{4'hE, 8'h90, 8'h02, 8'hE4, 4'b0011, 3};
    vecs[12] = '{4'hB, 8'h81, 8'h07, 8'h80, 4'b0011, 8};
    vecs[13] = '{4'hF, 8'h01, 8'h01, 8'h80, 4'b0111, 2};
    vecs[14] = '{4'h8, 8'h00, 8'h00, 8'h00, 4'b1101, 1};
    vecs[15] = '{4'h5, 8'h80, 8'h01, 8'h7F, 4'b0101, 1};
    vecs[16] = '{4'h1, 8'h55, 8'h00, 8'h00, 4'b1101, 1};
    vecs[17] = '{4'h3, 8'h55, 8'h7F, 8'h80, 4'b0111, 1};
    vecs[18] = '{4'hD, 8'h40, 8'h01, 8'h80, 4'b0011, 2};
    vecs[19] = '{4'hD, 8'h21, 8'h02, 8'h84, 4'b0011, 3};

    // Reset state, then in_ready must wait for the first edge after release.
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.FunSel = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst OutALU", int'(bus.OutALU), 0);
    checkOutput("rst Flags", int'(bus.Flags), 0);
    checkOutput("rst out_valid", int'(bus.out_valid), 0);
    checkOutput("rst in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    #1 checkOutput("release in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    checkOutput("first-edge in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, gOut, gFlags, lat, busy);
      checkOutput($sformatf("vec%0d OutALU", i), gOut, int'(vecs[i].out));
      checkOutput($sformatf("vec%0d Flags", i), gFlags, int'(vecs[i].flags));
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d busy", i), busy, 1);
    end

    // Backpressure: ADD result held while AND waits, then AND issues back-to-back.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.FunSel = 4'h4; bus.A = 8'h10; bus.B = 8'h20; bus.in_valid = 1'b1;
    checkOutput("bp accept", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.FunSel = 4'h7; bus.A = 8'hAA; bus.B = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("bp hold%0d OutALU", k), int'(bus.OutALU), 8'h30);
      checkOutput($sformatf("bp hold%0d Flags", k), int'(bus.Flags), 0);
      checkOutput($sformatf("bp hold%0d valid", k), int'(bus.out_valid), 1);
      checkOutput($sformatf("bp hold%0d in_ready", k), int'(bus.in_ready), 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1 checkOutput("bp release in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp AND OutALU", int'(bus.OutALU), 8'hA0);
    checkOutput("bp AND Flags", int'(bus.Flags), 4'b0010);
    checkOutput("bp AND valid", int'(bus.out_valid), 1);
    @(negedge clk);
    checkOutput("bp drained", int'(bus.out_valid), 0);

    // Reset during the third SHIFT cycle of LSL 0x01 by 7 discards the operation.
    applyStimulus(4'h5, 8'h00, 8'h01, gOut, gFlags, lat, busy);
    checkOutput("pre-rst OutALU", gOut, 8'hFF);
    checkOutput("pre-rst Flags", gFlags, 4'b0010);
    @(negedge clk);
    bus.FunSel = 4'hB; bus.A = 8'h01; bus.B = 8'h07; bus.in_valid = 1'b1;
    checkOutput("lsl accept", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst OutALU", int'(bus.OutALU), 0);
    checkOutput("midrst Flags", int'(bus.Flags), 0);
    checkOutput("midrst out_valid", int'(bus.out_valid), 0);
    checkOutput("midrst in_ready", int'(bus.in_ready), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("post-rst no result", int'(bus.out_valid), 0);
    applyStimulus(4'h4, 8'h01, 8'h01, gOut, gFlags, lat, busy);
    checkOutput("post-rst ADD OutALU", gOut, 8'h02);
    checkOutput("post-rst ADD Flags", gFlags, 0);
    checkOutput("post-rst ADD latency", lat, 1);
    mC = 1'b0;
    mO = 1'b0;

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      refModel(int'(rop), int'(ra), int'(rb), mC, mO, eOut, eFlags, eLat);
      mC = ((eFlags >> 2) & 1) != 0;
      mO = (eFlags & 1) != 0;
      applyStimulus(rop, ra, rb, gOut, gFlags, lat, busy);
      checkOutput($sformatf("rnd%0d op%0h OutALU", i, rop), gOut, eOut);
      checkOutput($sformatf("rnd%0d op%0h Flags", i, rop), gFlags, eFlags);
      checkOutput($sformatf("rnd%0d op%0h latency", i, rop), lat, eLat);
      checkOutput($sformatf("rnd%0d op%0h busy", i, rop), busy, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
